// File: rtl/c1_buscycle_ctrl.sv
// 68k bus-cycle controller: per-zone strobes, table-driven wait states, external wait
// stretching, nDTACK generation and a bus-error timeout for unmapped or stalled cycles.
//
// state   | meaning
// S_IDLE  | no cycle in progress, watching for nAS falling edge
// S_WAIT  | zone hit, counting wait states / held by nEXTWAIT
// S_ACK   | nDTACK asserted until nAS released
// S_UNMAP | no zone selected, waiting for timeout
// S_BERR  | nBERR asserted until nAS released
module c1_buscycle_ctrl #(
  parameter int                        NZONES     = 8,
  parameter int                        WAITW      = 2,
  parameter logic [NZONES*WAITW-1:0]   ZONE_WAITS = '0,
  parameter logic [NZONES-1:0]         EXT_MASK   = '0,
  parameter int                        TIMEOUT    = 64,
  parameter int                        TOW        = 7
) (
  input  logic              CLK_68KCLK,
  input  logic              RESET,
  input  logic              nAS,
  input  logic              RW,
  input  logic              nUDS,
  input  logic              nLDS,
  input  logic [NZONES-1:0] nZONE,
  input  logic              nEXTWAIT,
  output logic              nDTACK,
  output logic              nBERR,
  output logic [NZONES-1:0] nZONE_RD,
  output logic [NZONES-1:0] nZONE_WR,
  output logic              ZONE_CONFLICT,
  output logic              BUSY
);

  localparam int SELW = (NZONES > 1) ? $clog2(NZONES) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT,
    S_ACK,
    S_UNMAP,
    S_BERR
  } state_t;

  state_t            state, state_d;
  logic [WAITW-1:0]  wcnt, wcnt_d;
  logic [TOW-1:0]    tcnt, tcnt_d;
  logic              nas_q;
  logic [NZONES-1:0] rd_q, rd_d;
  logic [NZONES-1:0] wr_q, wr_d;
  logic              ext_q, ext_d;
  logic              conflict_q, conflict_d;

  logic [NZONES-1:0] zone_low;
  logic [NZONES-1:0] sel_onehot;
  logic [SELW-1:0]   sel;
  logic              hit;
  logic              multi;
  logic              start;
  logic              ext_hold;
  logic              timed_out;

  assign zone_low = ~nZONE;
  // clearing the lowest set bit leaves something only if two or more zones are selected
  assign multi    = |(zone_low & (zone_low - NZONES'(1)));

  always_comb begin
    hit = 1'b0;
    sel = '0;
    for (int i = NZONES - 1; i >= 0; i--) begin
      if (zone_low[i]) begin
        hit = 1'b1;
        sel = SELW'(i);
      end
    end
  end

  assign sel_onehot = NZONES'(1) << sel;
  assign start      = (state == S_IDLE) && !nAS && nas_q;
  assign ext_hold   = ext_q && !nEXTWAIT;
  assign timed_out  = (tcnt == TOW'(TIMEOUT - 1));

  always_ff @(posedge CLK_68KCLK or posedge RESET) begin
    if (RESET) begin
      state      <= S_IDLE;
      wcnt       <= '0;
      tcnt       <= '0;
      nas_q      <= 1'b1;
      rd_q       <= '0;
      wr_q       <= '0;
      ext_q      <= 1'b0;
      conflict_q <= 1'b0;
    end else begin
      state      <= state_d;
      wcnt       <= wcnt_d;
      tcnt       <= tcnt_d;
      nas_q      <= nAS;
      rd_q       <= rd_d;
      wr_q       <= wr_d;
      ext_q      <= ext_d;
      conflict_q <= conflict_d;
    end
  end

  always_comb begin
    state_d    = state;
    wcnt_d     = wcnt;
    tcnt_d     = tcnt;
    rd_d       = rd_q;
    wr_d       = wr_q;
    ext_d      = ext_q;
    conflict_d = 1'b0;

    case (state)
      S_IDLE: begin
        if (start) begin
          wcnt_d     = ZONE_WAITS[sel*WAITW +: WAITW];
          tcnt_d     = '0;
          ext_d      = hit && EXT_MASK[sel];
          conflict_d = multi;
          if (hit && !(nUDS && nLDS)) begin
            if (RW) rd_d = sel_onehot;
            else    wr_d = sel_onehot;
          end
          state_d = hit ? S_WAIT : S_UNMAP;
        end
      end
      S_WAIT: begin
        // a ready acknowledge wins over a timeout landing on the same edge
        if (wcnt == '0 && !ext_hold) begin
          state_d = S_ACK;
        end else if (timed_out) begin
          state_d = S_BERR;
          rd_d    = '0;
          wr_d    = '0;
        end else begin
          tcnt_d = tcnt + 1'b1;
          if (wcnt != '0) wcnt_d = wcnt - 1'b1;
        end
      end
      S_UNMAP: begin
        if (timed_out) state_d = S_BERR;
        else           tcnt_d  = tcnt + 1'b1;
      end
      default: ;
    endcase

    // nAS release ends or aborts any cycle on the same edge
    if (state != S_IDLE && nAS) begin
      state_d = S_IDLE;
      rd_d    = '0;
      wr_d    = '0;
    end
  end

  assign nDTACK        = (state != S_ACK);
  assign nBERR         = (state != S_BERR);
  assign BUSY          = (state != S_IDLE);
  assign nZONE_RD      = ~rd_q;
  assign nZONE_WR      = ~wr_q;
  assign ZONE_CONFLICT = conflict_q;

endmodule

// File: tb/tb_c1_buscycle_ctrl.sv
// Directed bench for c1_buscycle_ctrl: 4 zones with waits 0..3, zone 1 ext-wait masked,
// timeout of 8 cycles. Inputs change 1 time unit after a rising edge, outputs sampled there too.
module tb_c1_buscycle_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       nas = 1'b1;
  logic       rw = 1'b1;
  logic       nuds = 1'b1;
  logic       nlds = 1'b1;
  logic [3:0] nzone = 4'hF;
  logic       nextwait = 1'b1;
  logic       ndtack, nberr, conflict, busy;
  logic [3:0] nrd, nwr;

  int vectors = 0;
  int miscompares = 0;

  c1_buscycle_ctrl #(
    .NZONES(4),
    .WAITW(2),
    .ZONE_WAITS(8'hE4),
    .EXT_MASK(4'b0010),
    .TIMEOUT(8),
    .TOW(4)
  ) dut (
    .CLK_68KCLK(clk),
    .RESET(rst),
    .nAS(nas),
    .RW(rw),
    .nUDS(nuds),
    .nLDS(nlds),
    .nZONE(nzone),
    .nEXTWAIT(nextwait),
    .nDTACK(ndtack),
    .nBERR(nberr),
    .nZONE_RD(nrd),
    .nZONE_WR(nwr),
    .ZONE_CONFLICT(conflict),
    .BUSY(busy)
  );

  always #5 clk = ~clk;

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_reset;
    #2;
    vectors++; if (ndtack !== 1'b1) begin miscompares++; $display("FAIL rst_dtack: got %b exp 1", ndtack); end
    vectors++; if (nberr !== 1'b1) begin miscompares++; $display("FAIL rst_berr: got %b exp 1", nberr); end
    vectors++; if (nrd !== 4'hF) begin miscompares++; $display("FAIL rst_rd: got %b exp 1111", nrd); end
    vectors++; if (nwr !== 4'hF) begin miscompares++; $display("FAIL rst_wr: got %b exp 1111", nwr); end
    vectors++; if (conflict !== 1'b0) begin miscompares++; $display("FAIL rst_conflict: got %b exp 0", conflict); end
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL rst_busy: got %b exp 0", busy); end
    step(2);
    rst = 1'b0;
    step(1);
  endtask

  // zone 2 read, two wait states: nDTACK low after edge 3
  task automatic test_read_wait;
    nzone = 4'b1011; rw = 1'b1; nuds = 1'b0; nlds = 1'b0; nas = 1'b0;
    step(1);
    vectors++; if (nrd !== 4'b1011) begin miscompares++; $display("FAIL rd_strobe: got %b exp 1011", nrd); end
    vectors++; if (nwr !== 4'hF) begin miscompares++; $display("FAIL rd_no_wr: got %b exp 1111", nwr); end
    vectors++; if (busy !== 1'b1) begin miscompares++; $display("FAIL rd_busy: got %b exp 1", busy); end
    vectors++; if (conflict !== 1'b0) begin miscompares++; $display("FAIL rd_conflict: got %b exp 0", conflict); end
    vectors++; if (ndtack !== 1'b1) begin miscompares++; $display("FAIL rd_dtack_e0: got %b exp 1", ndtack); end
    for (int e = 1; e <= 4; e++) begin
      step(1);
      vectors++;
      if (ndtack !== ((e >= 3) ? 1'b0 : 1'b1)) begin
        miscompares++; $display("FAIL rd_dtack_e%0d: got %b exp %b", e, ndtack, (e >= 3) ? 1'b0 : 1'b1);
      end
    end
    vectors++; if (nrd !== 4'b1011) begin miscompares++; $display("FAIL rd_strobe_held: got %b exp 1011", nrd); end
    nas = 1'b1; nzone = 4'hF; nuds = 1'b1; nlds = 1'b1;
    step(1);
    vectors++; if (ndtack !== 1'b1) begin miscompares++; $display("FAIL rd_release_dtack: got %b exp 1", ndtack); end
    vectors++; if (nrd !== 4'hF) begin miscompares++; $display("FAIL rd_release_rd: got %b exp 1111", nrd); end
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL rd_release_busy: got %b exp 0", busy); end
  endtask

  // zone 0 write, W=0, lower byte only; nEXTWAIT low must not stretch an unmasked zone
  task automatic test_write_w0;
    nzone = 4'b1110; rw = 1'b0; nuds = 1'b1; nlds = 1'b0; nextwait = 1'b0; nas = 1'b0;
    step(1);
    vectors++; if (nwr !== 4'b1110) begin miscompares++; $display("FAIL wr_strobe: got %b exp 1110", nwr); end
    vectors++; if (nrd !== 4'hF) begin miscompares++; $display("FAIL wr_no_rd: got %b exp 1111", nrd); end
    vectors++; if (ndtack !== 1'b1) begin miscompares++; $display("FAIL wr_dtack_e0: got %b exp 1", ndtack); end
    step(1);
    vectors++; if (ndtack !== 1'b0) begin miscompares++; $display("FAIL wr_dtack_e1: got %b exp 0", ndtack); end
    vectors++; if (nrd !== 4'hF) begin miscompares++; $display("FAIL wr_no_rd_e1: got %b exp 1111", nrd); end
    nas = 1'b1; nzone = 4'hF; nlds = 1'b1; rw = 1'b1; nextwait = 1'b1;
    step(1);
    vectors++; if (nwr !== 4'hF) begin miscompares++; $display("FAIL wr_release: got %b exp 1111", nwr); end
    vectors++; if (ndtack !== 1'b1) begin miscompares++; $display("FAIL wr_release_dtack: got %b exp 1", ndtack); end
  endtask

  // zone 0 access with both data strobes high: acknowledged, but no strobe
  task automatic test_no_strobe;
    nzone = 4'b1110; rw = 1'b1; nuds = 1'b1; nlds = 1'b1; nas = 1'b0;
    step(1);
    vectors++; if (nrd !== 4'hF) begin miscompares++; $display("FAIL ns_rd: got %b exp 1111", nrd); end
    vectors++; if (busy !== 1'b1) begin miscompares++; $display("FAIL ns_busy: got %b exp 1", busy); end
    step(1);
    vectors++; if (ndtack !== 1'b0) begin miscompares++; $display("FAIL ns_dtack: got %b exp 0", ndtack); end
    nas = 1'b1; nzone = 4'hF;
    step(1);
  endtask

  // zone 1 (masked, W=1), nEXTWAIT low for the 5 edges after the wait count expires
  task automatic test_ext_wait;
    nzone = 4'b1101; rw = 1'b1; nuds = 1'b0; nlds = 1'b0; nextwait = 1'b0; nas = 1'b0;
    step(1);
    vectors++; if (nrd !== 4'b1101) begin miscompares++; $display("FAIL ext_strobe: got %b exp 1101", nrd); end
    for (int e = 1; e <= 6; e++) begin
      step(1);
      vectors++; if (ndtack !== 1'b1) begin miscompares++; $display("FAIL ext_dtack_e%0d: got %b exp 1", e, ndtack); end
      vectors++; if (busy !== 1'b1) begin miscompares++; $display("FAIL ext_busy_e%0d: got %b exp 1", e, busy); end
    end
    nextwait = 1'b1;
    step(1);
    vectors++; if (ndtack !== 1'b0) begin miscompares++; $display("FAIL ext_dtack_e7: got %b exp 0", ndtack); end
    vectors++; if (nberr !== 1'b1) begin miscompares++; $display("FAIL ext_berr_e7: got %b exp 1", nberr); end
    nas = 1'b1; nzone = 4'hF; nuds = 1'b1; nlds = 1'b1;
    step(1);
  endtask

  // zone 1 with nEXTWAIT stuck low: bus error after edge 8, strobe dropped
  task automatic test_ext_timeout;
    nzone = 4'b1101; rw = 1'b1; nuds = 1'b0; nlds = 1'b0; nextwait = 1'b0; nas = 1'b0;
    step(1);
    for (int e = 1; e <= 7; e++) begin
      step(1);
      vectors++; if (nberr !== 1'b1) begin miscompares++; $display("FAIL exto_berr_e%0d: got %b exp 1", e, nberr); end
    end
    step(1);
    vectors++; if (nberr !== 1'b0) begin miscompares++; $display("FAIL exto_berr_e8: got %b exp 0", nberr); end
    vectors++; if (ndtack !== 1'b1) begin miscompares++; $display("FAIL exto_dtack_e8: got %b exp 1", ndtack); end
    vectors++; if (nrd !== 4'hF) begin miscompares++; $display("FAIL exto_rd_e8: got %b exp 1111", nrd); end
    nas = 1'b1; nzone = 4'hF; nuds = 1'b1; nlds = 1'b1; nextwait = 1'b1;
    step(1);
    vectors++; if (nberr !== 1'b1) begin miscompares++; $display("FAIL exto_release: got %b exp 1", nberr); end
  endtask

  task automatic test_unmapped;
    nzone = 4'hF; rw = 1'b1; nuds = 1'b0; nlds = 1'b0; nas = 1'b0;
    step(1);
    vectors++; if (busy !== 1'b1) begin miscompares++; $display("FAIL um_busy: got %b exp 1", busy); end
    vectors++; if (nrd !== 4'hF) begin miscompares++; $display("FAIL um_rd: got %b exp 1111", nrd); end
    for (int e = 1; e <= 7; e++) begin
      step(1);
      vectors++; if (nberr !== 1'b1) begin miscompares++; $display("FAIL um_berr_e%0d: got %b exp 1", e, nberr); end
    end
    step(1);
    vectors++; if (nberr !== 1'b0) begin miscompares++; $display("FAIL um_berr_e8: got %b exp 0", nberr); end
    vectors++; if (ndtack !== 1'b1) begin miscompares++; $display("FAIL um_dtack_e8: got %b exp 1", ndtack); end
    step(1);
    vectors++; if (nberr !== 1'b0) begin miscompares++; $display("FAIL um_berr_e9: got %b exp 0", nberr); end
    nas = 1'b1; nuds = 1'b1; nlds = 1'b1;
    step(1);
    vectors++; if (nberr !== 1'b1) begin miscompares++; $display("FAIL um_release_berr: got %b exp 1", nberr); end
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL um_release_busy: got %b exp 0", busy); end
  endtask

  // zones 1 and 2 both selected: one-cycle conflict pulse, zone 1 served with W=1
  task automatic test_conflict;
    nzone = 4'b1001; rw = 1'b1; nuds = 1'b0; nlds = 1'b0; nas = 1'b0;
    step(1);
    vectors++; if (conflict !== 1'b1) begin miscompares++; $display("FAIL cf_pulse: got %b exp 1", conflict); end
    vectors++; if (nrd !== 4'b1101) begin miscompares++; $display("FAIL cf_strobe: got %b exp 1101", nrd); end
    nzone = 4'b0111;
    step(1);
    vectors++; if (conflict !== 1'b0) begin miscompares++; $display("FAIL cf_pulse_end: got %b exp 0", conflict); end
    vectors++; if (ndtack !== 1'b1) begin miscompares++; $display("FAIL cf_dtack_e1: got %b exp 1", ndtack); end
    vectors++; if (nrd !== 4'b1101) begin miscompares++; $display("FAIL cf_sel_latched: got %b exp 1101", nrd); end
    step(1);
    vectors++; if (ndtack !== 1'b0) begin miscompares++; $display("FAIL cf_dtack_e2: got %b exp 0", ndtack); end
    nas = 1'b1; nzone = 4'hF; nuds = 1'b1; nlds = 1'b1;
    step(1);
  endtask

  // asynchronous reset between edges while zone 2 is counting waits, then a clean cycle
  task automatic test_reset_mid_wait;
    nzone = 4'b1011; rw = 1'b1; nuds = 1'b0; nlds = 1'b0; nas = 1'b0;
    step(2);
    vectors++; if (nrd !== 4'b1011) begin miscompares++; $display("FAIL rm_pre_rd: got %b exp 1011", nrd); end
    #3;
    rst = 1'b1;
    #1;
    vectors++; if (nrd !== 4'hF) begin miscompares++; $display("FAIL rm_rd: got %b exp 1111", nrd); end
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL rm_busy: got %b exp 0", busy); end
    vectors++; if (ndtack !== 1'b1) begin miscompares++; $display("FAIL rm_dtack: got %b exp 1", ndtack); end
    nas = 1'b1; nzone = 4'hF; nuds = 1'b1; nlds = 1'b1;
    step(1);
    rst = 1'b0;
    step(1);
    test_read_wait();
  endtask

  initial begin
    test_reset();
    test_read_wait();
    test_write_w0();
    test_no_strobe();
    test_ext_wait();
    test_ext_timeout();
    test_unmapped();
    test_conflict();
    test_reset_mid_wait();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
